md_sequencer: RTL and testbench

- Multi-cycle multiply/divide controller for the E stage of the 5-stage pipeline.
- Accepts an MD operation from the E-stage operand muxes and owns the HI/LO registers.
- Models fixed multiply and divide latency with a counter-driven FSM.
- Exports start/busy to the hazard unit, which stalls MD-dependent instructions in D.

---
 rtl/md_pkg.sv | 34 +++
 rtl/md_if.sv | 25 ++
 rtl/md_arith.sv | 59 +++++
 rtl/md_sequencer.sv | 111 +++++++++++
 tb/tb_md_sequencer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared encodings, default latencies and FSM state type for the E-stage
// multiply/divide sequencer.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;
  localparam int MD_CNT_W_DEF       = 4;

  // Ops that occupy the unit for a latency window (mult/multu/div/divu).
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_if.sv
// E-stage <-> MD sequencer bundle. Master is the pipeline side issuing ops;
// slave is the sequencer that owns HI/LO.
interface md_if;
  logic [2:0]        md_op;
  logic [31:0]       md_a;
  logic [31:0]       md_b;
  logic              start;
  logic              busy;
  logic              done;
  logic [31:0]       hi_out;
  logic [31:0]       lo_out;
  md_pkg::md_state_e state;

  // No valid/ready pair: an op is taken only when start is high (FSM IDLE);
  // while busy the hazard unit stalls, and any op presented is dropped.
  modport master (
    output md_op, md_a, md_b,
    input  start, busy, done, hi_out, lo_out, state
  );

  modport slave (
    input  md_op, md_a, md_b,
    output start, busy, done, hi_out, lo_out, state
  );
endinterface

// File: rtl/md_arith.sv
// Combinational 64-bit multiply / 32-bit divide result generator for
// mult, multu, div and divu.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div_zero_o
);

  logic [63:0]        prod_u;
  logic signed [63:0] prod_s;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic [31:0]        q_s;
  logic [31:0]        r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  always_comb begin
    prod_u = {32'd0, a_i} * {32'd0, b_i};
    prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});

    // Sign-magnitude divide: 0x80000000 / -1 falls out as 0x80000000 rem 0.
    a_mag = a_i[31] ? (~a_i + 32'd1) : a_i;
    b_mag = b_i[31] ? (~b_i + 32'd1) : b_i;
    q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    q_s   = (a_i[31] ^ b_i[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s   = a_i[31] ? (~r_mag + 32'd1) : r_mag;

    q_u   = (b_i == 32'd0) ? 32'd0 : (a_i / b_i);
    r_u   = (b_i == 32'd0) ? 32'd0 : (a_i % b_i);

    res_hi_o = 32'd0;
    res_lo_o = 32'd0;
    case (op_i)
      MD_MULT:  {res_hi_o, res_lo_o} = prod_s;
      MD_MULTU: {res_hi_o, res_lo_o} = prod_u;
      MD_DIV: begin
        res_hi_o = r_s;
        res_lo_o = q_s;
      end
      MD_DIVU: begin
        res_hi_o = r_u;
        res_lo_o = q_u;
      end
      default: ;
    endcase

    div_zero_o = md_is_div(op_i) && (b_i == 32'd0);
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle mult/div controller for the E stage: fixed-latency FSM that
// owns HI/LO and reports start/busy/done to the hazard unit.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int CNT_W       = MD_CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic               pend_zero_q, pend_zero_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               div_zero;

  md_arith u_arith (
    .op_i       (bus.md_op),
    .a_i        (bus.md_a),
    .b_i        (bus.md_b),
    .res_hi_o   (res_hi),
    .res_lo_o   (res_lo),
    .div_zero_o (div_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_zero_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_zero_q <= pend_zero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_zero_d = pend_zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      IDLE: begin
        if (md_is_arith(bus.md_op)) begin
          state_d     = RUN;
          cnt_d       = md_is_div(bus.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          pend_hi_d   = res_hi;
          pend_lo_d   = res_lo;
          pend_zero_d = div_zero;
        end else if (bus.md_op == MD_MTHI) begin
          hi_d = bus.md_a;
        end else if (bus.md_op == MD_MTLO) begin
          lo_d = bus.md_a;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        // cnt==1 marks the last busy cycle; results land on its closing edge.
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!pend_zero_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == RUN) && (cnt_d == CNT_W'(1));
  end

  always_comb begin
    bus.start  = (state_q == IDLE) && md_is_arith(bus.md_op);
    bus.busy   = busy_q;
    bus.done   = done_q;
    bus.hi_out = hi_q;
    bus.lo_out = lo_q;
    bus.state  = state_q;
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: hand-computed HI/LO results and cycle-exact
// start/busy/done timing, including mid-operation reset and back-to-back issue.
module tb_md_sequencer;
  import md_pkg::*;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  md_if bus ();

  md_sequencer #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.md_op = op;
    bus.md_a  = a;
    bus.md_b  = b;
  endtask

  // Issue an arith op in the current cycle and follow it through n busy cycles,
  // returning in cycle n+1 with HI/LO checked against expectations.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = bus.hi_out;
    old_lo = bus.lo_out;
    drive(op, a, b);
    #1;
    check({tag, " start c0"}, 32'(bus.start), 32'd1);
    check({tag, " busy c0"}, 32'(bus.busy), 32'd0);
    tick();
    drive(MD_NONE, 32'd0, 32'd0);
    for (int k = 1; k <= n; k++) begin
      check($sformatf("%s busy c%0d", tag, k), 32'(bus.busy), 32'd1);
      check($sformatf("%s done c%0d", tag, k), 32'(bus.done), (k == n) ? 32'd1 : 32'd0);
      check($sformatf("%s hold hi c%0d", tag, k), bus.hi_out, old_hi);
      check($sformatf("%s hold lo c%0d", tag, k), bus.lo_out, old_lo);
      if (k == 1) check({tag, " state RUN"}, 32'(bus.state), 32'(RUN));
      tick();
    end
    check({tag, " busy end"}, 32'(bus.busy), 32'd0);
    check({tag, " done end"}, 32'(bus.done), 32'd0);
    check({tag, " hi"}, bus.hi_out, exp_hi);
    check({tag, " lo"}, bus.lo_out, exp_lo);
  endtask

  task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] a);
    drive(op, a, 32'd0);
    #1;
    check({tag, " start"}, 32'(bus.start), 32'd0);
    tick();
    drive(MD_NONE, 32'd0, 32'd0);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b0;
    drive(MD_NONE, 32'd0, 32'd0);
    tick();
    tick();
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst hi", bus.hi_out, 32'd0);
    check("rst lo", bus.lo_out, 32'd0);
    check("rst start", 32'(bus.start), 32'd0);
    check("rst state", 32'(bus.state), 32'(IDLE));
    reset = 1'b1;
    tick();

    run_op("mult -2*3", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("divu 100/7", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);

    move_to("mthi", MD_MTHI, 32'h1234_5678);
    check("mthi hi", bus.hi_out, 32'h1234_5678);
    move_to("mtlo", MD_MTLO, 32'h9ABC_DEF0);
    check("mtlo lo", bus.lo_out, 32'h9ABC_DEF0);
    check("mtlo hi kept", bus.hi_out, 32'h1234_5678);
    run_op("div by 0", MD_DIV, 32'd55, 32'd0, 10, 32'h1234_5678, 32'h9ABC_DEF0);
    tick();
    run_op("divu by 0", MD_DIVU, 32'd55, 32'd0, 10, 32'h1234_5678, 32'h9ABC_DEF0);

    // multu in flight, mtlo while busy, then an asynchronous reset mid-run.
    drive(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    check("abort start c0", 32'(bus.start), 32'd1);
    tick();
    drive(MD_NONE, 32'd0, 32'd0);
    tick();
    drive(MD_MTLO, 32'd1, 32'd0);
    #1;
    check("busy mtlo start", 32'(bus.start), 32'd0);
    check("busy mtlo busy", 32'(bus.busy), 32'd1);
    tick();
    drive(MD_NONE, 32'd0, 32'd0);
    check("busy mtlo ignored", bus.lo_out, 32'h9ABC_DEF0);
    reset = 1'b0;
    #1;
    check("async rst busy", 32'(bus.busy), 32'd0);
    check("async rst hi", bus.hi_out, 32'd0);
    check("async rst lo", bus.lo_out, 32'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("post rst busy %0d", k), 32'(bus.busy), 32'd0);
      check($sformatf("post rst done %0d", k), 32'(bus.done), 32'd0);
      check($sformatf("post rst hi %0d", k), bus.hi_out, 32'd0);
      check($sformatf("post rst lo %0d", k), bus.lo_out, 32'd0);
      tick();
    end

    run_op("b2b 2*3", MD_MULT, 32'd2, 32'd3, 5, 32'd0, 32'd6);
    run_op("b2b 4*5", MD_MULT, 32'd4, 32'd5, 5, 32'd0, 32'd20);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
